// File: rtl/buzzer_pkg.sv
// Shared types and tone table for the buzzer player.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned TONE_HZ [8] = '{500, 1000, 2000, 3000, 4000, 5000, 6000, 8000};

  // Half period in clk cycles; tones at or above clk/2 clamp to a single cycle.
  function automatic int unsigned half_cyc(input int unsigned clk_hz, input logic [2:0] idx);
    int unsigned h;
    h = clk_hz / (2 * TONE_HZ[idx]);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/buzzer_player_tone_gen.sv
// Square-wave generator: restarts low, toggles every HALF cycles while run is high,
// and is held low whenever run is low.
module tone_gen
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int N_KEY  = 4,
  localparam int IW    = (N_KEY > 1) ? $clog2(N_KEY) : 1
) (
  input  logic          clk_sel,
  input  logic          sys_rst_n,
  input  logic          restart,
  input  logic          run,
  input  logic [IW-1:0] tone_sel,
  output logic          beeper
);

  localparam int HALF_MAX = half_cyc(CLK_HZ, 3'd0);
  localparam int HW       = $clog2(HALF_MAX + 1);

  logic [HW-1:0] half_tab [N_KEY];
  logic [HW-1:0] cnt;
  logic [HW-1:0] half_m1;

  for (genvar g = 0; g < N_KEY; g++) begin : g_half
    assign half_tab[g] = HW'(half_cyc(CLK_HZ, 3'(g)) - 1);
  end

  assign half_m1 = half_tab[tone_sel];

  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt    <= '0;
      beeper <= 1'b0;
    end else if (restart) begin
      cnt    <= half_m1;
      beeper <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        cnt    <= half_m1;
        beeper <= ~beeper;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      cnt    <= '0;
      beeper <= 1'b0;
    end
  end

endmodule

// File: rtl/buzzer_player.sv
// Key-triggered beep-burst sequencer: key k plays k+1 beeps of tone k.
// Optional BUZZER_STOP_EN adds a stop input that aborts any burst.
//
// state | meaning
// IDLE  | silent, waiting for a key pulse
// TONE  | beep in progress, square wave running
// GAP   | silence between beeps of one burst
module buzzer_player
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int N_KEY   = 4,
  parameter int BEEP_MS = 100,
  parameter int GAP_MS  = 50,
  localparam int IW     = (N_KEY > 1) ? $clog2(N_KEY) : 1
) (
  input  logic             clk_sel,
  input  logic             sys_rst_n,
  input  logic [N_KEY-1:0] key_pos,
`ifdef BUZZER_STOP_EN
  input  logic             stop,
`endif
  output logic             beeper,
  output logic             busy,
  output logic [IW-1:0]    tone_idx
);

  localparam int BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int CYC_MAX  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int DW       = $clog2(CYC_MAX + 1);
  localparam int BLW      = $clog2(N_KEY + 1);
  localparam logic [DW-1:0] BEEP_M1 = DW'(BEEP_CYC - 1);
  localparam logic [DW-1:0] GAP_M1  = DW'(GAP_CYC - 1);

  state_t         state;
  logic [DW-1:0]  dur;
  logic [BLW-1:0] beeps_left;
  logic [IW-1:0]  key_sel;
  logic           key_hit;
  logic           stop_req;
  logic           tg_restart;
  logic           tg_run;
  logic [IW-1:0]  tg_sel;

`ifdef BUZZER_STOP_EN
  assign stop_req = stop;
`else
  assign stop_req = 1'b0;
`endif

  always_comb begin
    key_sel = '0;
    for (int i = N_KEY - 1; i >= 0; i--) begin
      if (key_pos[i]) key_sel = IW'(i);
    end
  end

  assign key_hit = |key_pos;

  // Divider restarts on every burst (re)start and on each gap-to-tone transition.
  assign tg_restart = !stop_req && (key_hit || (state == GAP && dur == '0));
  assign tg_run     = !stop_req && !key_hit && state == TONE && dur != '0;
  assign tg_sel     = key_hit ? key_sel : tone_idx;

  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      tone_idx   <= '0;
      dur        <= '0;
      beeps_left <= '0;
    end else if (stop_req) begin
      state      <= IDLE;
      busy       <= 1'b0;
      dur        <= '0;
      beeps_left <= '0;
    end else if (key_hit) begin
      state      <= TONE;
      busy       <= 1'b1;
      tone_idx   <= key_sel;
      beeps_left <= BLW'(key_sel) + 1'b1;
      dur        <= BEEP_M1;
    end else begin
      case (state)
        TONE: begin
          if (dur == '0) begin
            beeps_left <= beeps_left - 1'b1;
            if (beeps_left == BLW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              dur   <= GAP_M1;
            end
          end else begin
            dur <= dur - 1'b1;
          end
        end
        GAP: begin
          if (dur == '0) begin
            state <= TONE;
            dur   <= BEEP_M1;
          end else begin
            dur <= dur - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  tone_gen #(
    .CLK_HZ(CLK_HZ),
    .N_KEY (N_KEY)
  ) u_tone_gen (
    .clk_sel  (clk_sel),
    .sys_rst_n(sys_rst_n),
    .restart  (tg_restart),
    .run      (tg_run),
    .tone_sel (tg_sel),
    .beeper   (beeper)
  );

endmodule

// File: tb/tb_buzzer_player.sv
// Self-checking bench for buzzer_player at CLK_HZ=24000, BEEP_MS=GAP_MS=1.
module tb_buzzer_player;

  localparam int BEEP = 24;
  localparam int GAP  = 24;
  localparam int FREQ [4] = '{500, 1000, 2000, 3000};

  logic       clk_sel;
  logic       sys_rst_n;
  logic [3:0] key_pos;
`ifdef BUZZER_STOP_EN
  logic       stop;
`endif
  logic       beeper;
  logic       busy;
  logic [1:0] tone_idx;

  int checks = 0;
  int errors = 0;

  bit m_active;
  int m_k;
  int m_p;

  typedef struct {
    logic [3:0] key;
    int         exp_busy;
    int         exp_rises;
    int         exp_idx;
  } vec_t;

  vec_t vecs [6];

  buzzer_player #(
    .CLK_HZ (24000),
    .N_KEY  (4),
    .BEEP_MS(1),
    .GAP_MS (1)
  ) dut (
    .clk_sel  (clk_sel),
    .sys_rst_n(sys_rst_n),
    .key_pos  (key_pos),
`ifdef BUZZER_STOP_EN
    .stop     (stop),
`endif
    .beeper   (beeper),
    .busy     (busy),
    .tone_idx (tone_idx)
  );

  initial clk_sel = 1'b0;
  always #5 clk_sel = ~clk_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int half_of(input int k);
    int h;
    h = 24000 / (2 * FREQ[k]);
    return (h == 0) ? 1 : h;
  endfunction

  // Burst as a timeline: beep n occupies [n*(B+G), n*(B+G)+B), square wave starts low.
  task automatic model_out(output bit b, output bit bz);
    int total;
    int seg;
    total = BEEP * (m_k + 1) + GAP * m_k;
    b  = 1'b0;
    bz = 1'b0;
    if (m_active && m_p < total) begin
      bz  = 1'b1;
      seg = m_p % (BEEP + GAP);
      if (seg < BEEP) b = ((seg / half_of(m_k)) % 2) == 1;
    end
  endtask

  task automatic model_update(input logic [3:0] key);
    if (key != 4'b0) begin
      for (int i = 3; i >= 0; i--) if (key[i]) m_k = i;
      m_p      = 0;
      m_active = 1'b1;
    end else if (m_active) begin
      m_p++;
    end
  endtask

  task automatic check_model();
    bit eb, ebz;
    model_out(eb, ebz);
    chk("beeper", 32'(beeper), 32'(eb));
    chk("busy", 32'(busy), 32'(ebz));
    chk("tone_idx", 32'(tone_idx), 32'(m_k));
  endtask

  // Called just after a falling edge; applies key for one rising edge.
  task automatic cyc(input logic [3:0] key);
    key_pos = key;
    @(posedge clk_sel);
    model_update(key);
    @(negedge clk_sel);
    key_pos = 4'b0;
    check_model();
  endtask

  initial begin
    int busy_cnt, rises, n;
    logic prev_b;

    vecs[0] = '{4'b0001, 24,  0,  0};
    vecs[1] = '{4'b0010, 72,  2,  1};
    vecs[2] = '{4'b0100, 120, 6,  2};
    vecs[3] = '{4'b1000, 168, 12, 3};
    vecs[4] = '{4'b1010, 72,  2,  1};
    vecs[5] = '{4'b1111, 24,  0,  0};

    m_active  = 1'b0;
    m_k       = 0;
    m_p       = 0;
    key_pos   = 4'b0;
`ifdef BUZZER_STOP_EN
    stop      = 1'b0;
`endif
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk_sel);
    chk("reset_beeper", 32'(beeper), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_idx", 32'(tone_idx), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) cyc(4'b0);

    foreach (vecs[v]) begin
      cyc(vecs[v].key);
      chk("vec_idx", 32'(tone_idx), 32'(vecs[v].exp_idx));
      busy_cnt = 0;
      rises    = 0;
      prev_b   = 1'b0;
      n        = 0;
      while (busy && n < 400) begin
        busy_cnt++;
        if (beeper && !prev_b) rises++;
        prev_b = beeper;
        cyc(4'b0);
        n++;
      end
      chk("vec_busy_cycles", 32'(busy_cnt), 32'(vecs[v].exp_busy));
      chk("vec_rises", 32'(rises), 32'(vecs[v].exp_rises));
      repeat (3) cyc(4'b0);
    end

    // Preempt ten cycles into the second beep of tone 3.
    cyc(4'b1000);
    repeat (57) cyc(4'b0);
    cyc(4'b0001);
    chk("preempt_beeper", 32'(beeper), 32'd0);
    chk("preempt_busy", 32'(busy), 32'd1);
    chk("preempt_idx", 32'(tone_idx), 32'd0);
    busy_cnt = 0;
    n        = 0;
    while (busy && n < 400) begin
      busy_cnt++;
      cyc(4'b0);
      n++;
    end
    chk("preempt_busy_cycles", 32'(busy_cnt), 32'd24);

    // Asynchronous reset in the middle of a gap.
    cyc(4'b0100);
    repeat (29) cyc(4'b0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_beeper", 32'(beeper), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_idx", 32'(tone_idx), 32'd0);
    m_active = 1'b0;
    m_k      = 0;
    @(negedge clk_sel);
    sys_rst_n = 1'b1;
    repeat (150) cyc(4'b0);

`ifdef BUZZER_STOP_EN
    stop = 1'b1;
    cyc(4'b0001);
    stop = 1'b0;
    m_active = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_beeper", 32'(beeper), 32'd0);
    repeat (30) cyc(4'b0);
    cyc(4'b0100);
    repeat (10) cyc(4'b0);
    stop = 1'b1;
    cyc(4'b0);
    stop = 1'b0;
    m_active = 1'b0;
    chk("stop_mid_busy", 32'(busy), 32'd0);
    repeat (30) cyc(4'b0);
`endif

    for (int it = 0; it < 40; it++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      cyc(k);
      repeat ($urandom_range(0, 150)) cyc(4'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/buzzer_player.md
BUZZER_PLAYER -- requirements
Module: buzzer_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk_sel frequency in Hz.
REQ-002 SHALL have parameter N_KEY, default 4, meaning the number of trigger keys and tones (1..8).
REQ-003 SHALL have parameter BEEP_MS, default 100, meaning the tone-on duration per beep in ms.
REQ-004 SHALL have parameter GAP_MS, default 50, meaning the silence between beeps of one burst in ms.
REQ-005 SHALL have port clk_sel, input, 1 bit, meaning the block clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1 bit, meaning reset (asynchronous, active-low).
REQ-007 SHALL have port key_pos, input, N_KEY bits, meaning one-cycle key-press pulses, synchronous to clk_sel.
REQ-008 SHALL have port beeper, output, 1 bit, meaning the square-wave drive to the buzzer.
REQ-009 SHALL have port busy, output, 1 bit, meaning a burst is in progress.
REQ-010 SHALL have port tone_idx, output, $clog2(N_KEY) bits (minimum 1), meaning the index of the active tone.

Function
REQ-011 SHALL implement FSM states IDLE, TONE and GAP; busy is 1 in TONE and GAP only.
REQ-012 In IDLE, any key_pos bit set SHALL select k, the lowest set index; latch tone_idx=k and beeps_left=k+1; enter TONE on the next cycle.
REQ-013 In TONE, beeper SHALL toggle every HALF[k] cycles, where HALF[k] = CLK_HZ/(2*TONE_HZ[k]) with integer truncation; the first toggle is HALF[k] cycles after TONE entry.
REQ-014 TONE SHALL last exactly BEEP_CYC = CLK_HZ/1000*BEEP_MS cycles; at exit beeper is forced to 0 and beeps_left is decremented.
REQ-015 At TONE exit, beeps_left=0 SHALL go to IDLE; otherwise the FSM SHALL go to GAP.
REQ-016 GAP SHALL last exactly GAP_CYC = CLK_HZ/1000*GAP_MS cycles with beeper=0, then return to TONE with the tone divider restarted.
REQ-017 A key_pos pulse while busy=1 SHALL preempt the burst: re-select k per REQ-012, reload counters, and enter TONE on the next cycle with beeper=0.
REQ-018 key_pos=0 SHALL have no effect; multiple set bits in one cycle SHALL resolve to the lowest index.
REQ-019 Counter widths SHALL be derived with $clog2 from HALF and BEEP_CYC/GAP_CYC maxima; counters SHALL never wrap.
REQ-020 HALF[k]=0 (tone at or above CLK_HZ/2) SHALL be clamped to 1.

Reset
REQ-021 Asserting sys_rst_n low at any time, including mid-burst, SHALL immediately force state=IDLE, beeper=0, busy=0, tone_idx=0, and all counters to 0.
REQ-022 After deassertion, the first key_pos SHALL be honoured no earlier than the first clk_sel rising edge.

Configuration
REQ-023 Macro BUZZER_STOP_EN, when defined, SHALL add input stop (1 bit); stop=1 in any state forces IDLE with beeper=0 on the next cycle, and stop takes priority over a simultaneous key_pos.
REQ-024 Without BUZZER_STOP_EN, the stop port and its logic SHALL be absent, and a burst ends only per REQ-015, REQ-017 or REQ-021.

Structure
REQ-025 Package buzzer_pkg SHALL hold the FSM state typedef (IDLE, TONE, GAP) and the TONE_HZ constant table (500, 1000, 2000, 3000, 4000, 5000, 6000, 8000 Hz).
REQ-026 The square-wave generator (HALF load, toggle counter, restart and force-low) SHALL be a sub-module tone_gen; the FSM and duration counters SHALL remain in buzzer_player.

Verification (CLK_HZ=24000, BEEP_MS=1, GAP_MS=1, so BEEP_CYC=GAP_CYC=24 and HALF = 24, 12, 6, 4)
REQ-027 key_pos=4'b0001 -> busy high for 24 cycles; beeper toggles at cycle 24 of TONE only, then is forced to 0; tone_idx=0; one beep.
REQ-028 key_pos=4'b0100 -> three beeps; each has toggles every 6 cycles during 24 cycles, separated by 24-cycle gaps; busy high for 120 cycles.
REQ-029 key_pos=4'b1010 -> tone 1 selected; HALF=12; two beeps.
REQ-030 key_pos=4'b1000, then key_pos=4'b0001 ten cycles into the second beep -> immediate restart with a single tone-0 beep; beeper=0 at the restart cycle.
REQ-031 sys_rst_n pulsed low mid-GAP -> beeper, busy and tone_idx are 0 asynchronously; no further beeps follow.
REQ-032 With BUZZER_STOP_EN defined, stop=1 and key_pos=4'b0001 in the same cycle -> IDLE; beeper stays 0.
